// File: rtl/md_cart_bus_arbiter.sv
// rtl/md_cart_bus_arbiter.sv - cartridge memory port arbiter: cart reads over host writes, with starvation guard
module md_cart_bus_arbiter #(
  parameter int ADDR_W        = 22,
  parameter int HOST_MAX_WAIT = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic              MCLK,
  input  logic              ext_reset,
  input  logic              cart_req,
  input  logic [ADDR_W-1:0] cart_addr,
  output logic [15:0]       cart_data,
  output logic              cart_ack,
  output logic              cart_err,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic              host_ack,
  output logic              host_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(HOST_MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, CART_RD, HOST_WR, ACK} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            owner_cart;
  logic            err;
  logic            grant_host;
  logic            grant_cart;
  logic            busy;
  logic            tmo_hit;

  // Host wins only when cart is idle or the cart has already been granted HOST_MAX_WAIT times in a row.
  assign grant_host = host_req && ((starve_cnt == SW'(HOST_MAX_WAIT)) || !cart_req);
  assign grant_cart = cart_req && !grant_host;
  assign busy       = (state == CART_RD) || (state == HOST_WR);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT));

  always_ff @(posedge MCLK or posedge ext_reset) begin
    if (ext_reset) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_host)      state_nx = HOST_WR;
        else if (grant_cart) state_nx = CART_RD;
      end
      CART_RD, HOST_WR: begin
        if (mem_ready || tmo_hit) state_nx = ACK;
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or posedge ext_reset) begin
    if (ext_reset) begin
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      owner_cart <= 1'b0;
      err        <= 1'b0;
      cart_data  <= 16'h0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_host) begin
            starve_cnt <= '0;
            mem_addr   <= host_addr;
            mem_wdata  <= host_wdata;
            owner_cart <= 1'b0;
            tmo_cnt    <= TW'(1);
          end else if (grant_cart) begin
            if (!host_req)
              starve_cnt <= '0;
            else if (starve_cnt != SW'(HOST_MAX_WAIT))
              starve_cnt <= starve_cnt + SW'(1);
            mem_addr   <= cart_addr;
            owner_cart <= 1'b1;
            tmo_cnt    <= TW'(1);
          end
        end
        CART_RD, HOST_WR: begin
          // tmo_cnt counts cycles spent in the state, so the abort lands after exactly TIMEOUT cycles.
          if (mem_ready) begin
            if (owner_cart) cart_data <= mem_rdata;
          end else if (tmo_hit) begin
            err <= 1'b1;
            if (owner_cart) cart_data <= 16'hFFFF;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ACK:     err <= 1'b0;
        default: err <= 1'b0;
      endcase
    end
  end

  always_comb begin
    mem_req  = busy;
    mem_we   = (state == HOST_WR);
    cart_ack = (state == ACK) && owner_cart;
    host_ack = (state == ACK) && !owner_cart;
    cart_err = cart_ack && err;
    host_err = host_ack && err;
  end

endmodule
